// File: rtl/uart_echo_master.sv
// uart_echo_master: local-bus initiator that polls the UART control block and
// echoes every received byte back to the transmitter.
//
// Handshake: a bus cycle is one ADDR cycle (cs_=0, as_=0) followed by WAIT
// cycles (cs_=0, as_=1) until rdy_=0 is sampled on a rising edge; that edge
// ends the cycle and captures rd_data. rdy_ is ignored outside WAIT. At least
// one idle cycle (cs_=1) always separates two bus cycles.
module uart_echo_master #(
    parameter int unsigned POLL_GAP = 4,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        cs_,
    output logic        as_,
    output logic        rw,
    output logic        addr,
    output logic [31:0] wr_data,
    input  logic [31:0] rd_data,
    input  logic        rdy_,
    output logic [7:0]  echo_cnt,
    output logic [7:0]  last_byte,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_POLL, ST_RXCLR, ST_RDDAT, ST_TXCHK, ST_TXWR, ST_GAP
    } state_t;

    // Bus phase of the current step; PH_IDLE covers separator and gap cycles.
    typedef enum logic [1:0] {
        PH_IDLE, PH_ADDR, PH_WAIT
    } phase_t;

    localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    phase_t     phase_q, phase_d;
    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       tx_int_q, tx_int_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] echo_cnt_q, echo_cnt_d;
    logic [7:0] last_byte_q, last_byte_d;
    logic       bus_err_q, bus_err_d;
    logic       active;

    // Upper read-data bits carry nothing this master needs.
    logic unused_rd;
    assign unused_rd = ^rd_data[31:8];

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_IDLE;
            idle_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            tx_int_q    <= 1'b0;
            byte_q      <= '0;
            echo_cnt_q  <= '0;
            last_byte_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idle_cnt_q  <= idle_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            tx_int_q    <= tx_int_d;
            byte_q      <= byte_d;
            echo_cnt_q  <= echo_cnt_d;
            last_byte_q <= last_byte_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Next-state logic: sequence step, bus phase, idle and timeout counters.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        idle_cnt_d  = idle_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        tx_int_d    = tx_int_q;
        byte_d      = byte_q;
        echo_cnt_d  = echo_cnt_q;
        last_byte_d = last_byte_q;
        bus_err_d   = bus_err_q;
        case (phase_q)
            PH_IDLE: begin
                if (state_q == ST_IDLE) begin
                    if (enable) begin
                        state_d = ST_POLL;
                        phase_d = PH_ADDR;
                    end
                end else if (idle_cnt_q != 8'd0) begin
                    idle_cnt_d = idle_cnt_q - 8'd1;
                end else if (state_q == ST_GAP) begin
                    if (enable) begin
                        state_d = ST_POLL;
                        phase_d = PH_ADDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    phase_d = PH_ADDR;
                end
            end
            PH_ADDR: begin
                phase_d    = PH_WAIT;
                wait_cnt_d = '0;
            end
            PH_WAIT: begin
                if (!rdy_) begin
                    // Cycle complete: one separator cycle unless overridden.
                    phase_d    = PH_IDLE;
                    idle_cnt_d = '0;
                    wait_cnt_d = '0;
                    case (state_q)
                        ST_POLL: begin
                            tx_int_d = rd_data[1];
                            if (rd_data[0]) begin
                                state_d = ST_RXCLR;
                            end else begin
                                state_d    = ST_GAP;
                                idle_cnt_d = GAP_LAST;
                            end
                        end
                        ST_RXCLR: state_d = ST_RDDAT;
                        ST_RDDAT: begin
                            byte_d  = rd_data[7:0];
                            state_d = ST_TXCHK;
                        end
                        ST_TXCHK: begin
                            if (rd_data[3]) begin
                                idle_cnt_d = GAP_LAST;
                            end else begin
                                state_d = ST_TXWR;
                            end
                        end
                        ST_TXWR: begin
                            echo_cnt_d  = echo_cnt_q + 8'd1;
                            last_byte_d = byte_q;
                            state_d     = ST_GAP;
                            idle_cnt_d  = GAP_LAST;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else if (wait_cnt_q == TO_LAST) begin
                    // Slave never answered: abandon the sequence.
                    bus_err_d  = 1'b1;
                    state_d    = ST_GAP;
                    phase_d    = PH_IDLE;
                    idle_cnt_d = GAP_LAST;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    // Bus outputs decoded from the registered step and phase.
    always_comb begin
        active  = (phase_q != PH_IDLE);
        cs_     = !active;
        as_     = (phase_q != PH_ADDR);
        rw      = !(active && (state_q == ST_RXCLR || state_q == ST_TXWR));
        addr    = active && (state_q == ST_RDDAT || state_q == ST_TXWR);
        wr_data = '0;
        if (active && state_q == ST_RXCLR) wr_data = {30'b0, tx_int_q, 1'b0};
        if (active && state_q == ST_TXWR)  wr_data = {24'b0, byte_q};
    end

    assign echo_cnt  = echo_cnt_q;
    assign last_byte = last_byte_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_uart_echo_master.sv
// Bench for uart_echo_master: reactive bus slave, transaction monitor,
// per-cycle vector table for idle polling, and echo transactions checked
// against an expected transaction list built from the echo protocol.
module tb_uart_echo_master;

    localparam int POLL_GAP = 4;
    localparam int TIMEOUT  = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        cs_, as_, rw, addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data = 32'h0;
    logic        rdy_ = 1'b1;
    logic [7:0]  echo_cnt, last_byte;
    logic        bus_err;

    uart_echo_master #(.POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cs_(cs_), .as_(as_), .rw(rw), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .rdy_(rdy_),
        .echo_cnt(echo_cnt), .last_byte(last_byte), .bus_err(bus_err)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Slave: status responses queue, data register, latency control
    logic [31:0] stat_q[$];
    logic [31:0] data_val = 32'h0;
    bit          no_rdy = 1'b0;
    int          max_lat = 0;
    int          w_cnt = 0;
    int          cur_lat = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!cs_ && as_) begin
                if (!no_rdy && w_cnt >= cur_lat) begin
                    rdy_ = 1'b0;
                    if (rw && !addr) begin
                        if (stat_q.size() > 0) rd_data = stat_q.pop_front();
                        else rd_data = 32'h0;
                    end else if (rw) begin
                        rd_data = data_val;
                    end else begin
                        rd_data = $urandom();
                    end
                end else begin
                    rdy_ = 1'b1;
                end
                w_cnt++;
            end else begin
                rdy_    = 1'($urandom_range(0, 1));
                w_cnt   = 0;
                cur_lat = $urandom_range(0, max_lat);
                rd_data = $urandom();
            end
        end
    end

    // Monitor: every completed bus cycle with its ADDR and completion cycles
    typedef struct {
        logic [33:0] key;
        int          start;
        int          fin;
    } txn_t;
    txn_t act_q[$];
    int   cur_start = 0;

    always @(negedge clk) begin
        txn_t t;
        if (!cs_ && !as_) cur_start = cyc;
        if (!cs_ && as_ && !rdy_) begin
            t.key   = {rw, addr, wr_data};
            t.start = cur_start;
            t.fin   = cyc;
            act_q.push_back(t);
        end
    end

    // Reference model state and scoreboard
    int          model_cnt = 0;
    logic [33:0] exp_q[$];

    // One echo: poll sees rx_int, clear, read data, busy_n busy TXCHKs, write.
    task automatic run_echo(input logic tx_bit, input logic [7:0] data,
                            input int busy_n, input bit drop_en);
        int guard;
        int need;
        int gap_exp;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cs_ !== 1'b1 && guard < 200);
        act_q.delete();
        stat_q.delete();
        exp_q.delete();
        stat_q.push_back({30'b0, tx_bit, 1'b1});
        for (int i = 0; i < busy_n; i++) stat_q.push_back(32'h8 | ($urandom() & 32'h2));
        stat_q.push_back(32'h0);
        data_val = ($urandom() & 32'hFFFF_FF00) | {24'b0, data};
        exp_q.push_back({1'b1, 1'b0, 32'h0});
        exp_q.push_back({1'b0, 1'b0, 30'b0, tx_bit, 1'b0});
        exp_q.push_back({1'b1, 1'b1, 32'h0});
        for (int i = 0; i <= busy_n; i++) exp_q.push_back({1'b1, 1'b0, 32'h0});
        exp_q.push_back({1'b0, 1'b1, 24'b0, data});
        need = exp_q.size() + (drop_en ? 0 : 1);
        guard = 0;
        while (act_q.size() < need && guard < 3000) begin
            @(negedge clk);
            if (drop_en && !cs_ && !as_ && addr && rw) enable = 1'b0;
            guard++;
        end
        if (guard >= 3000) check("echo_done", 64'(act_q.size()), 64'(need));
        repeat (2) @(negedge clk);
        model_cnt++;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < act_q.size()) check($sformatf("txn%0d", i), 64'(act_q[i].key), 64'(exp_q[i]));
        end
        for (int i = 1; i < need; i++) begin
            if (i < act_q.size()) begin
                if (i - 1 >= 3 && i - 1 < 3 + busy_n) gap_exp = POLL_GAP;
                else if (i == exp_q.size()) gap_exp = POLL_GAP;
                else gap_exp = 1;
                check($sformatf("idle_before_txn%0d", i),
                      64'(act_q[i].start - act_q[i-1].fin - 1), 64'(gap_exp));
            end
        end
        check("echo_cnt", 64'(echo_cnt), 64'(model_cnt % 256));
        check("last_byte", 64'(last_byte), 64'(data));
    endtask

    // Idle-poll vector table
    typedef struct {
        logic en;
        logic exp_cs;
        logic exp_as;
        logic exp_rw;
        logic exp_addr;
    } vec_t;
    vec_t vecs[12];

    initial begin
        int guard;
        int n;
        int idle_seen;

        for (int i = 0; i < 12; i++) begin
            vecs[i].en       = 1'b1;
            vecs[i].exp_cs   = !(i % 6 == 0 || i % 6 == 1);
            vecs[i].exp_as   = !(i % 6 == 0);
            vecs[i].exp_rw   = 1'b1;
            vecs[i].exp_addr = 1'b0;
        end

        // Reset with enable held high
        reset = 1'b1;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs", 64'(cs_), 64'(1));
        check("rst_as", 64'(as_), 64'(1));
        check("rst_rw", 64'(rw), 64'(1));
        check("rst_addr", 64'(addr), 64'(0));
        check("rst_wr_data", 64'(wr_data), 64'(0));
        check("rst_echo_cnt", 64'(echo_cnt), 64'(0));
        check("rst_last_byte", 64'(last_byte), 64'(0));
        check("rst_bus_err", 64'(bus_err), 64'(0));
        reset = 1'b0;

        // Idle polling with zero-latency slave and status 0
        max_lat = 0;
        for (int i = 0; i < 12; i++) begin
            enable = vecs[i].en;
            @(negedge clk);
            check($sformatf("poll_cs_%0d", i), 64'(cs_), 64'(vecs[i].exp_cs));
            check($sformatf("poll_as_%0d", i), 64'(as_), 64'(vecs[i].exp_as));
            check($sformatf("poll_rw_%0d", i), 64'(rw), 64'(vecs[i].exp_rw));
            check($sformatf("poll_addr_%0d", i), 64'(addr), 64'(vecs[i].exp_addr));
        end

        // Single echoes, then TX busy for three TXCHK reads
        run_echo(1'b0, 8'h5A, 0, 1'b0);
        run_echo(1'b1, 8'hC3, 0, 1'b0);
        run_echo(1'b0, 8'h81, 3, 1'b0);

        // Randomized echoes up to 256 total, random slave latency
        while (model_cnt < 256) begin
            max_lat = $urandom_range(0, 3);
            run_echo(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                     $urandom_range(0, 2), 1'b0);
        end
        check("wrap_echo_cnt", 64'(echo_cnt), 64'(0));

        // Drop enable during the data read: echo completes, then silence
        max_lat = 1;
        run_echo(1'b1, 8'h3C, 1, 1'b1);
        idle_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cs_ !== 1'b1) idle_seen++;
        end
        check("stopped_no_cycles", 64'(idle_seen), 64'(0));

        // Timeout: slave never answers
        no_rdy = 1'b1;
        enable = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(cs_ === 1'b0 && as_ === 1'b0) && guard < 100);
        check("to_addr_seen", 64'(guard < 100), 64'(1));
        repeat (TIMEOUT) @(negedge clk);
        check("to_cs_last_wait", 64'(cs_), 64'(0));
        check("to_err_before", 64'(bus_err), 64'(0));
        @(negedge clk);
        check("to_cs_abort", 64'(cs_), 64'(1));
        check("to_err_set", 64'(bus_err), 64'(1));
        no_rdy = 1'b0;
        max_lat = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cs_ === 1'b0 && as_ === 1'b0) && n < 50);
        check("to_poll_resume", 64'(n), 64'(POLL_GAP));
        repeat (10) @(negedge clk);
        check("to_err_sticky", 64'(bus_err), 64'(1));
        check("to_echo_cnt", 64'(echo_cnt), 64'(model_cnt % 256));

        // Reset during a WAIT phase
        no_rdy = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(cs_ === 1'b0 && as_ === 1'b1) && guard < 100);
        reset = 1'b1;
        @(negedge clk);
        model_cnt = 0;
        check("wrst_cs", 64'(cs_), 64'(1));
        check("wrst_as", 64'(as_), 64'(1));
        check("wrst_rw", 64'(rw), 64'(1));
        check("wrst_wr_data", 64'(wr_data), 64'(0));
        check("wrst_echo_cnt", 64'(echo_cnt), 64'(model_cnt));
        check("wrst_bus_err", 64'(bus_err), 64'(0));
        reset = 1'b0;
        no_rdy = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
